// File: rtl/pixel_signature_pkg.sv
// Shared types, CRC constants and the byte-wide CRC-16/CCITT-FALSE step
// used by the pixel signature block.
package pixel_signature_pkg;

    localparam int unsigned COLOR_W     = 6;
    localparam int unsigned CRC_W       = 16;
    localparam int unsigned PIX_CNT_W   = 19;
    localparam int unsigned FRAME_CNT_W = 8;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        ACCUM,
        DONE
    } sig_state_t;

    // Fold one byte into the CRC, MSB first, no reflection.
    function automatic logic [CRC_W-1:0] crc16_step8(input logic [CRC_W-1:0] crc,
                                                     input logic [7:0]       data);
        logic [CRC_W-1:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/pixel_signature_beam_tracker.sv
// Reconstructs the beam position from the line/frame strobes and produces a
// registered sample strobe for every active pixel.
//   clk_i, rst_ni      clock, synchronous active-low reset
//   next_vertical_i    end-of-line strobe (level, may be several cycles)
//   next_frame_i       end-of-frame strobe (level, may be several cycles)
//   sample             high in the cycle whose colour must be hashed
//   frame_edge         one-cycle pulse, hcnt = 0 in that cycle
//   line_edge          one-cycle pulse, suppressed when a frame edge coincides
module beam_tracker #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_START  = 320,
    parameter int unsigned V_START  = 0,
    parameter int unsigned PIX_DIV  = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic next_vertical_i,
    input  logic next_frame_i,
    output logic sample,
    output logic frame_edge,
    output logic line_edge
);

    localparam int unsigned H_END  = H_START + PIX_DIV * H_ACTIVE;
    localparam int unsigned HCNT_W = $clog2(H_END + 2);
    localparam int unsigned LINE_W = $clog2(V_START + V_ACTIVE + 2);

    localparam logic [HCNT_W-1:0] HCNT_MAX = '1;
    localparam logic [LINE_W-1:0] LINE_MAX = '1;

    logic              nv_d;
    logic              nf_d;
    logic [HCNT_W-1:0] hcnt;
    logic [LINE_W-1:0] line;
    logic [HCNT_W-1:0] hcnt_next;
    logic [LINE_W-1:0] line_next;
    logic              frame_edge_raw;
    logic              line_edge_raw;

    assign frame_edge_raw = next_frame_i & ~nf_d;
    assign line_edge_raw  = next_vertical_i & ~nv_d;

    // True when (h, l) lands on a pixel inside the active window.
    function automatic logic is_active(input logic [HCNT_W-1:0] h,
                                       input logic [LINE_W-1:0] l);
        int dh;
        int dl;
        dh = int'(h) - int'(H_START);
        dl = int'(l) - int'(V_START);
        return (dh >= 0) && ((dh % int'(PIX_DIV)) == 0) &&
               ((dh / int'(PIX_DIV)) < int'(H_ACTIVE)) &&
               (dl >= 0) && (dl < int'(V_ACTIVE));
    endfunction

    // Next beam position; frame edge takes priority, counters saturate.
    always_comb begin
        hcnt_next = hcnt;
        line_next = line;
        if (frame_edge_raw) begin
            hcnt_next = '0;
            line_next = '0;
        end else if (line_edge_raw) begin
            hcnt_next = '0;
            if (line != LINE_MAX) begin
                line_next = line + LINE_W'(1);
            end
        end else if (hcnt != HCNT_MAX) begin
            hcnt_next = hcnt + HCNT_W'(1);
        end
    end

    // Sample is computed from the next position so it is registered yet
    // aligned with the cycle holding that position.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            nv_d       <= 1'b0;
            nf_d       <= 1'b0;
            hcnt       <= HCNT_MAX;
            line       <= '0;
            frame_edge <= 1'b0;
            line_edge  <= 1'b0;
            sample     <= 1'b0;
        end else begin
            nv_d       <= next_vertical_i;
            nf_d       <= next_frame_i;
            hcnt       <= hcnt_next;
            line       <= line_next;
            frame_edge <= frame_edge_raw;
            line_edge  <= line_edge_raw & ~frame_edge_raw;
            sample     <= is_active(hcnt_next, line_next);
        end
    end

endmodule

// File: rtl/pixel_signature.sv
// Frame signature generator: CRC-16 over the active pixels of one frame,
// delivered through a valid/ready result port.
//   clk_i, rst_ni      clock, synchronous active-low reset
//   rrggbb_i           pixel colour (registered upstream)
//   next_vertical_i    end-of-line strobe
//   next_frame_i       end-of-frame strobe
//   arm_i              capture the next complete frame
//   continuous_i       re-arm automatically at frame end
//   sig_valid_o/sig_ready_i   result handshake
//   sig_crc_o, sig_pixels_o, sig_frame_o   result payload
//   busy_o             capture in progress
//   overrun_o          sticky: unconsumed result overwritten
module pixel_signature
    import pixel_signature_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_START  = 320,
    parameter int unsigned V_START  = 0,
    parameter int unsigned PIX_DIV  = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [COLOR_W-1:0]     rrggbb_i,
    input  logic                   next_vertical_i,
    input  logic                   next_frame_i,
    input  logic                   arm_i,
    input  logic                   continuous_i,
    output logic                   sig_valid_o,
    input  logic                   sig_ready_i,
    output logic [CRC_W-1:0]       sig_crc_o,
    output logic [PIX_CNT_W-1:0]   sig_pixels_o,
    output logic [FRAME_CNT_W-1:0] sig_frame_o,
    output logic                   busy_o,
    output logic                   overrun_o
);

    sig_state_t           state;
    logic [CRC_W-1:0]     crc;
    logic [PIX_CNT_W-1:0] pix_cnt;
    logic                 sample;
    logic                 frame_edge;
    logic                 line_edge_unused;  // line structure is handled inside the tracker

    beam_tracker #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_START  (H_START),
        .V_START  (V_START),
        .PIX_DIV  (PIX_DIV)
    ) u_beam_tracker (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .next_vertical_i (next_vertical_i),
        .next_frame_i    (next_frame_i),
        .sample          (sample),
        .frame_edge      (frame_edge),
        .line_edge       (line_edge_unused)
    );

    // Capture FSM, CRC accumulator and result port.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= IDLE;
            crc          <= CRC_INIT;
            pix_cnt      <= '0;
            sig_valid_o  <= 1'b0;
            sig_crc_o    <= '0;
            sig_pixels_o <= '0;
            sig_frame_o  <= '0;
            busy_o       <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            // Handshake first; a latch later in this block re-asserts valid.
            if (sig_valid_o && sig_ready_i) begin
                sig_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (arm_i) begin
                        state     <= WAIT_FRAME;
                        busy_o    <= 1'b1;
                        overrun_o <= 1'b0;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_edge) begin
                        state   <= ACCUM;
                        crc     <= CRC_INIT;
                        pix_cnt <= '0;
                    end
                end
                ACCUM: begin
                    if (frame_edge) begin
                        sig_crc_o    <= crc;
                        sig_pixels_o <= pix_cnt;
                        sig_valid_o  <= 1'b1;
                        sig_frame_o  <= sig_frame_o + FRAME_CNT_W'(1);
                        if (sig_valid_o && !sig_ready_i) begin
                            overrun_o <= 1'b1;
                        end
                        crc     <= CRC_INIT;
                        pix_cnt <= '0;
                        if (!continuous_i) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                        end
                    end else if (sample) begin
                        crc <= crc16_step8(crc, {2'b00, rrggbb_i});
                        if (pix_cnt != '1) begin
                            pix_cnt <= pix_cnt + PIX_CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (sig_valid_o && sig_ready_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
